spi_bus_master: RTL and testbench

- Downstream consumer of spi_bridge.
- Takes the bridge's pending read/write request (addr/data/rw_n/valid) and executes it as one bus cycle on the PET memory bus, inside the MCU time slot granted by the system timing generator.
- Returns read data and a level "ready" to the bridge using a 4-phase handshake.

---
 rtl/spi_bus_pkg.sv | 17 +
 rtl/spi_bus_master.sv | 135 +++++++++++++
 tb/tb_spi_bus_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_pkg.sv
// Shared types and widths for the PET memory bus master that serves spi_bridge requests.
package spi_bus_pkg;

    localparam int BUS_ADDR_WIDTH = 17;
    localparam int BUS_DATA_WIDTH = 8;
    localparam int BUS_CNT_WIDTH  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } spi_bus_state_t;

endpackage

// File: rtl/spi_bus_master.sv
// Executes one pending spi_bridge request as a single PET bus cycle inside the granted MCU slot,
// then returns read data and a level ready using a 4-phase handshake.
module spi_bus_master
    import spi_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH    = BUS_DATA_WIDTH,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4
) (
    input  logic                  clk_sys_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] spi_addr_i,
    input  logic [DATA_WIDTH-1:0] spi_data_i,
    input  logic                  spi_rw_ni,
    input  logic                  spi_valid_i,
    output logic [DATA_WIDTH-1:0] spi_data_o,
    output logic                  spi_ready_o,
    input  logic                  slot_grant_i,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_data_oe_o,
    output logic                  bus_rw_no,
    output logic                  bus_strobe_o,
    output logic                  bus_active_o,
    input  logic [DATA_WIDTH-1:0] bus_data_i
);

    localparam logic [BUS_CNT_WIDTH-1:0] SETUP_LOAD  = BUS_CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [BUS_CNT_WIDTH-1:0] STROBE_LOAD = BUS_CNT_WIDTH'(STROBE_CYCLES - 1);

    spi_bus_state_t           state_q;
    logic [BUS_CNT_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0]    busAddr_q;
    logic [DATA_WIDTH-1:0]    busData_q;
    logic [DATA_WIDTH-1:0]    spiData_q;
    logic                     busDataOe_q;
    logic                     busRwN_q;
    logic                     busStrobe_q;
    logic                     busActive_q;
    logic                     spiReady_q;
    logic                     acceptGrant;

    // The bus output registers double as the request latch, so nothing is sampled after acceptance.
    assign acceptGrant = spi_valid_i && slot_grant_i &&
                         ((state_q == IDLE) || (state_q == WAIT_SLOT));

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            busAddr_q   <= '0;
            busData_q   <= '0;
            spiData_q   <= '0;
            busDataOe_q <= 1'b0;
            busRwN_q    <= 1'b1;
            busStrobe_q <= 1'b0;
            busActive_q <= 1'b0;
            spiReady_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (spi_valid_i) begin
                        state_q <= slot_grant_i ? SETUP : WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    if (!spi_valid_i) begin
                        state_q <= IDLE;
                    end else if (slot_grant_i) begin
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (count_q == '0) begin
                        state_q     <= STROBE;
                        count_q     <= STROBE_LOAD;
                        busStrobe_q <= 1'b1;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                STROBE: begin
                    if (count_q == '0) begin
                        state_q     <= HOLD;
                        busStrobe_q <= 1'b0;
                        if (busRwN_q) begin
                            spiData_q <= bus_data_i;
                        end
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                HOLD: begin
                    // Withdrawn requests finish the bus cycle but never raise ready.
                    state_q     <= spi_valid_i ? DONE : IDLE;
                    spiReady_q  <= spi_valid_i;
                    busAddr_q   <= '0;
                    busData_q   <= '0;
                    busDataOe_q <= 1'b0;
                    busRwN_q    <= 1'b1;
                    busActive_q <= 1'b0;
                end
                DONE: begin
                    if (!spi_valid_i) begin
                        state_q    <= IDLE;
                        spiReady_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (acceptGrant) begin
                count_q     <= SETUP_LOAD;
                busActive_q <= 1'b1;
                busAddr_q   <= spi_addr_i;
                busRwN_q    <= spi_rw_ni;
                busDataOe_q <= !spi_rw_ni;
                busData_q   <= spi_rw_ni ? '0 : spi_data_i;
            end
        end
    end

    assign spi_data_o    = spiData_q;
    assign spi_ready_o   = spiReady_q;
    assign bus_addr_o    = busAddr_q;
    assign bus_data_o    = busData_q;
    assign bus_data_oe_o = busDataOe_q;
    assign bus_rw_no     = busRwN_q;
    assign bus_strobe_o  = busStrobe_q;
    assign bus_active_o  = busActive_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Table-driven bench for spi_bus_master with a bus-cycle scoreboard and hand-written corner sequences.
module tb_spi_bus_master;

    localparam int SETUP    = 2;
    localparam int STROBE   = 4;
    localparam int READY_AT = SETUP + STROBE + 2;

    typedef struct {
        bit          rwN;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  busRead;
        int          grantDelay;
        int          dropAt;
        bit          busyGrant;
    } vector_t;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        bit          rwN;
    } busExp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [16:0] spiAddr = '0;
    logic [7:0]  spiData = '0;
    logic        spiRwN = 1'b1;
    logic        spiValid = 1'b0;
    logic [7:0]  spiDataOut;
    logic        spiReady;
    logic        slotGrant = 1'b0;
    logic [16:0] busAddr;
    logic [7:0]  busDataOut;
    logic        busDataOe;
    logic        busRwN;
    logic        busStrobe;
    logic        busActive;
    logic [7:0]  busDataIn = '0;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  modelData = '0;
    busExp_t     sbQueue[$];
    busExp_t     curExp;
    vector_t     vecs[7];

    logic        prevStrobe = 1'b0;
    int          setupCnt = 0;
    int          strobeCnt = 0;

    spi_bus_master #(
        .ADDR_WIDTH   (17),
        .DATA_WIDTH   (8),
        .SETUP_CYCLES (SETUP),
        .STROBE_CYCLES(STROBE)
    ) dut (
        .clk_sys_i    (clock),
        .reset_i      (reset),
        .spi_addr_i   (spiAddr),
        .spi_data_i   (spiData),
        .spi_rw_ni    (spiRwN),
        .spi_valid_i  (spiValid),
        .spi_data_o   (spiDataOut),
        .spi_ready_o  (spiReady),
        .slot_grant_i (slotGrant),
        .bus_addr_o   (busAddr),
        .bus_data_o   (busDataOut),
        .bus_data_oe_o(busDataOe),
        .bus_rw_no    (busRwN),
        .bus_strobe_o (busStrobe),
        .bus_active_o (busActive),
        .bus_data_i   (busDataIn)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busAddr"}, busAddr, 0);
        checkOutput({tag, "_busData"}, busDataOut, 0);
        checkOutput({tag, "_spiData"}, spiDataOut, 0);
        checkOutput({tag, "_oe"}, busDataOe, 0);
        checkOutput({tag, "_strobe"}, busStrobe, 0);
        checkOutput({tag, "_active"}, busActive, 0);
        checkOutput({tag, "_ready"}, spiReady, 0);
        checkOutput({tag, "_rwN"}, busRwN, 1);
    endtask

    // Each strobe burst must match exactly one queued request, with correct setup/strobe lengths.
    always @(negedge clock) begin
        if (reset) begin
            prevStrobe = 1'b0;
            setupCnt   = 0;
            strobeCnt  = 0;
        end else begin
            if (busStrobe && !prevStrobe) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sbExtraCycle", 1, 0);
                end else begin
                    curExp = sbQueue.pop_front();
                    checkOutput("sbAddr", busAddr, curExp.addr);
                    checkOutput("sbRwN", busRwN, curExp.rwN);
                    checkOutput("sbOe", busDataOe, !curExp.rwN);
                    if (!curExp.rwN) checkOutput("sbWData", busDataOut, curExp.data);
                    checkOutput("sbSetupLen", setupCnt, SETUP);
                end
            end
            if (busStrobe) begin
                strobeCnt++;
            end else if (busActive && !prevStrobe && strobeCnt == 0) begin
                setupCnt++;
            end
            if (!busStrobe && prevStrobe) begin
                checkOutput("sbStrobeLen", strobeCnt, STROBE);
                checkOutput("sbHoldActive", busActive, 1);
                checkOutput("sbHoldAddr", busAddr, curExp.addr);
                checkOutput("sbHoldOe", busDataOe, !curExp.rwN);
            end
            if (!busActive) begin
                setupCnt  = 0;
                strobeCnt = 0;
            end
            prevStrobe = busStrobe;
        end
    end

    task automatic applyStimulus(input vector_t v);
        spiAddr   = v.addr;
        spiData   = v.wdata;
        spiRwN    = v.rwN;
        spiValid  = 1'b1;
        busDataIn = ~v.busRead;
        for (int i = 0; i < v.grantDelay; i++) begin
            tick();
            checkOutput("waitSlotIdle", busActive, 0);
        end
        slotGrant = 1'b1;
        sbQueue.push_back('{addr: v.addr, data: v.wdata, rwN: v.rwN});
        tick();
        slotGrant = 1'b0;
        for (int k = 1; k <= READY_AT; k++) begin
            busDataIn = (k == SETUP + STROBE) ? v.busRead : ~v.busRead;
            if (k == 1) begin
                checkOutput("setupActive", busActive, 1);
                checkOutput("setupAddr", busAddr, v.addr);
            end
            if (k == v.dropAt) spiValid = 1'b0;
            if (v.busyGrant && k == 2) spiAddr = ~v.addr;
            if (v.busyGrant) slotGrant = (k == 3);
            if (k == READY_AT - 1) begin
                checkOutput("holdStrobe", busStrobe, 0);
                checkOutput("holdActive", busActive, 1);
                checkOutput("holdReady", spiReady, 0);
            end
            if (k == READY_AT) begin
                if (v.rwN) modelData = v.busRead;
                checkOutput("ready", spiReady, (v.dropAt == 0));
                checkOutput("readData", spiDataOut, modelData);
                checkOutput("postActive", busActive, 0);
                checkOutput("postRwN", busRwN, 1);
                checkOutput("postOe", busDataOe, 0);
            end else begin
                tick();
            end
        end
        slotGrant = 1'b0;
        if (spiValid) begin
            checkOutput("readyHeld", spiReady, 1);
            spiValid = 1'b0;
            tick();
            checkOutput("readyDrop", spiReady, 0);
        end else begin
            tick();
            checkOutput("noReady", spiReady, 0);
        end
        tick();
    endtask

    initial begin
        vecs[0] = '{rwN: 1'b0, addr: 17'h08000, wdata: 8'h55, busRead: 8'h00, grantDelay: 0, dropAt: 0, busyGrant: 1'b0};
        vecs[1] = '{rwN: 1'b1, addr: 17'h18001, wdata: 8'h00, busRead: 8'hA5, grantDelay: 0, dropAt: 0, busyGrant: 1'b0};
        vecs[2] = '{rwN: 1'b0, addr: 17'h1FFFF, wdata: 8'hFF, busRead: 8'h00, grantDelay: 3, dropAt: 0, busyGrant: 1'b0};
        vecs[3] = '{rwN: 1'b1, addr: 17'h00000, wdata: 8'h00, busRead: 8'h3C, grantDelay: 1, dropAt: 0, busyGrant: 1'b0};
        vecs[4] = '{rwN: 1'b0, addr: 17'h0AAAA, wdata: 8'h0F, busRead: 8'h00, grantDelay: 0, dropAt: 4, busyGrant: 1'b0};
        vecs[5] = '{rwN: 1'b1, addr: 17'h15555, wdata: 8'h00, busRead: 8'h81, grantDelay: 2, dropAt: 4, busyGrant: 1'b0};
        vecs[6] = '{rwN: 1'b0, addr: 17'h01234, wdata: 8'h9E, busRead: 8'h00, grantDelay: 0, dropAt: 0, busyGrant: 1'b1};

        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();
        checkResetValues("afterRelease");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Request withdrawn while waiting for a slot never reaches the bus.
        spiAddr  = 17'h02222;
        spiRwN   = 1'b0;
        spiValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("wsActive", busActive, 0);
        end
        spiValid = 1'b0;
        tick();
        slotGrant = 1'b1;
        tick();
        slotGrant = 1'b0;
        for (int i = 0; i < SETUP + 2; i++) begin
            tick();
            checkOutput("wsNoBus", busActive, 0);
            checkOutput("wsNoReady", spiReady, 0);
        end

        // Reset in the middle of a write strobe drops the bus immediately.
        spiAddr   = 17'h0ABCD;
        spiData   = 8'hC3;
        spiRwN    = 1'b0;
        spiValid  = 1'b1;
        slotGrant = 1'b1;
        sbQueue.push_back('{addr: 17'h0ABCD, data: 8'hC3, rwN: 1'b0});
        tick();
        slotGrant = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("preResetStrobe", busStrobe, 1);
        reset = 1'b1;
        #1;
        checkResetValues("midReset");
        spiValid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        modelData = '0;
        tick();
        applyStimulus('{rwN: 1'b0, addr: 17'h00010, wdata: 8'h6A, busRead: 8'h00, grantDelay: 0, dropAt: 0, busyGrant: 1'b0});

        repeat (4) tick();
        checkOutput("sbEmpty", sbQueue.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
